// File: rtl/motor_pkg.sv
// Shared register map, CTRL bit positions and drive-state encoding for motor_drive_ctrl.
package motor_pkg;

  localparam logic [3:0] BLOCK_SEL = 4'd6;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_TARGET_L  = 3'd1;
  localparam logic [2:0] REG_TARGET_R  = 3'd2;
  localparam logic [2:0] REG_RAMP_STEP = 3'd3;
  localparam logic [2:0] REG_STATUS    = 3'd4;
  localparam logic [2:0] REG_ACT_L     = 3'd5;
  localparam logic [2:0] REG_ACT_R     = 3'd6;

  localparam int unsigned CTRL_ENABLE    = 0;
  localparam int unsigned CTRL_ESTOP     = 1;
  localparam int unsigned CTRL_CLR_FAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2,
    ST_FAULT    = 2'd3
  } drive_state_t;

endpackage

// File: rtl/motor_drive_ctrl_ramp.sv
// Slew-limited pulse-width register for one motor side: moves act toward target by at most
// step per tick (step 0 = jump), with an immediate force-to-zero path.
module duty_ramp #(
  parameter int unsigned PW_W = 17
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic            tick,
  input  logic            force_zero,
  input  logic [PW_W-1:0] target,
  input  logic [PW_W-1:0] step,
  output logic [PW_W-1:0] act,
  output logic            changed
);

  logic            rising;
  logic [PW_W:0]   delta;
  logic [PW_W:0]   move;
  logic [PW_W:0]   nxt;

  // Extra bit keeps the subtraction/addition free of wrap before truncation.
  always_comb begin
    rising = (target >= act);
    delta  = '0;
    move   = '0;
    nxt    = {1'b0, act};
    if (rising) delta = {1'b0, target} - {1'b0, act};
    else        delta = {1'b0, act} - {1'b0, target};
    if ((step == '0) || ({1'b0, step} >= delta)) move = delta;
    else                                         move = {1'b0, step};
    if (rising) nxt = {1'b0, act} + move;
    else        nxt = {1'b0, act} - move;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      act     <= '0;
      changed <= 1'b0;
    end else if (force_zero) begin
      act     <= '0;
      changed <= (act != '0);
    end else if (tick) begin
      act     <= nxt[PW_W-1:0];
      changed <= (nxt != {1'b0, act});
    end else begin
      changed <= 1'b0;
    end
  end

endmodule

// File: rtl/motor_drive_ctrl.sv
// APB-mapped left/right motor drive controller: target registers, soft-start/stop ramp,
// command watchdog and e-stop sequencing feeding the PWM pulse-width words.
module motor_drive_ctrl
  import motor_pkg::*;
#(
  parameter int unsigned PERIOD     = 100000,
  parameter int unsigned PW_W       = 17,
  parameter int unsigned RAMP_DIV   = 1000,
  parameter int unsigned WDOG_TICKS = 200
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic            PWRITE,
  input  logic [31:0]     PADDR,
  input  logic [31:0]     PWDATA,
  output logic [31:0]     PRDATA,
  output logic            PREADY,
  output logic            PSLVERR,
  output logic [PW_W-1:0] pw_left,
  output logic [PW_W-1:0] pw_right,
  output logic            pw_valid,
  output logic            fault
);

  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned WD_W  = $clog2(WDOG_TICKS + 1);
  localparam logic [PW_W-1:0] PERIOD_PW = PW_W'(PERIOD);

  drive_state_t     state;
  logic             enable;
  logic [PW_W-1:0]  tgt_l, tgt_r, ramp_step;
  logic [DIV_W-1:0] div_cnt;
  logic [WD_W-1:0]  wdog_cnt;
  logic             wdog_exp;
  logic             tick;

  logic             blk_sel, wr, ctrl_wr, estop, clr_fault, tgt_wr, wdog_expire;
  logic [2:0]       reg_idx;
  logic [PW_W-1:0]  wdata_clamped;
  logic [PW_W-1:0]  eff_l, eff_r, act_l, act_r;
  logic             chg_l, chg_r, force_zero, at_target;
  logic             unused_paddr;

  assign blk_sel   = (PADDR[11:8] == BLOCK_SEL);
  assign reg_idx   = PADDR[4:2];
  assign wr        = PSEL & PENABLE & PWRITE & blk_sel;
  assign ctrl_wr   = wr && (reg_idx == REG_CTRL);
  assign estop     = ctrl_wr & PWDATA[CTRL_ESTOP];
  assign clr_fault = ctrl_wr & PWDATA[CTRL_CLR_FAULT];
  assign tgt_wr    = wr && ((reg_idx == REG_TARGET_L) || (reg_idx == REG_TARGET_R));
  assign wdata_clamped = (PWDATA > 32'(PERIOD)) ? PERIOD_PW : PWDATA[PW_W-1:0];
  assign unused_paddr  = ^{PADDR[31:12], PADDR[7:5], PADDR[1:0]};

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      enable    <= 1'b0;
      tgt_l     <= '0;
      tgt_r     <= '0;
      ramp_step <= '0;
    end else if (wr) begin
      case (reg_idx)
        REG_CTRL:      enable    <= PWDATA[CTRL_ENABLE];
        REG_TARGET_L:  tgt_l     <= wdata_clamped;
        REG_TARGET_R:  tgt_r     <= wdata_clamped;
        REG_RAMP_STEP: ramp_step <= PWDATA[PW_W-1:0];
        default: ;
      endcase
    end
  end

  assign tick = (div_cnt == DIV_W'(RAMP_DIV - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // A TARGET write landing on the expiring tick reloads instead of expiring.
  assign wdog_expire = (state == ST_RUN) && tick && (wdog_cnt <= WD_W'(1)) && !tgt_wr;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= ST_IDLE;
      fault    <= 1'b0;
      wdog_cnt <= '0;
      wdog_exp <= 1'b0;
    end else begin
      if (tgt_wr)
        wdog_cnt <= WD_W'(WDOG_TICKS);
      else if ((state == ST_RUN) && tick && (wdog_cnt != '0))
        wdog_cnt <= wdog_cnt - 1'b1;

      if (estop) begin
        state <= ST_FAULT;
        fault <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (enable) begin
            state    <= ST_RUN;
            wdog_cnt <= WD_W'(WDOG_TICKS);
          end
          ST_RUN: if (!enable) begin
            state <= ST_STOPPING;
          end else if (wdog_expire) begin
            state    <= ST_STOPPING;
            wdog_exp <= 1'b1;
          end
          ST_STOPPING: if ((act_l == '0) && (act_r == '0)) begin
            if (wdog_exp) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_FAULT: if (clr_fault) begin
            state    <= ST_IDLE;
            fault    <= 1'b0;
            wdog_exp <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign eff_l      = (state == ST_RUN) ? tgt_l : '0;
  assign eff_r      = (state == ST_RUN) ? tgt_r : '0;
  assign force_zero = estop || (state == ST_IDLE) || (state == ST_FAULT);

  duty_ramp #(.PW_W(PW_W)) u_ramp_l (
    .PCLK(PCLK), .PRESET(PRESET), .tick(tick), .force_zero(force_zero),
    .target(eff_l), .step(ramp_step), .act(act_l), .changed(chg_l)
  );

  duty_ramp #(.PW_W(PW_W)) u_ramp_r (
    .PCLK(PCLK), .PRESET(PRESET), .tick(tick), .force_zero(force_zero),
    .target(eff_r), .step(ramp_step), .act(act_r), .changed(chg_r)
  );

  assign pw_left   = act_l;
  assign pw_right  = act_r;
  assign pw_valid  = chg_l | chg_r;
  assign at_target = (act_l == eff_l) && (act_r == eff_r);

  always_comb begin
    PRDATA = '0;
    if (PSEL && blk_sel) begin
      case (reg_idx)
        REG_CTRL:      PRDATA = {31'd0, enable};
        REG_TARGET_L:  PRDATA = 32'(tgt_l);
        REG_TARGET_R:  PRDATA = 32'(tgt_r);
        REG_RAMP_STEP: PRDATA = 32'(ramp_step);
        REG_STATUS:    PRDATA = {27'd0, at_target, wdog_exp, fault, state};
        REG_ACT_L:     PRDATA = 32'(act_l);
        REG_ACT_R:     PRDATA = 32'(act_r);
        default:       PRDATA = '0;
      endcase
    end
  end

endmodule
